// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selection: single request wins outright; on contention
// either requester 0 (fixed priority) or whoever was not granted last.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic prio_fixed_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = REQ_CPU;
    if (req0_i && req1_i) begin
      winner_o = prio_fixed_i ? REQ_CPU : ~last_grant_i;
    end else if (req1_i) begin
      winner_o = REQ_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous memory between cpu (0) and loader (1);
// each access is a fixed IDLE -> ACC -> RSP sequence of one cycle per state.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prio_fixed,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .prio_fixed_i (prio_fixed),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  // Requester inputs and prio_fixed are only looked at in IDLE.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_winner;
          last_grant_d = pick_winner;
          we_d         = pick_winner ? we1    : we0;
          addr_d       = pick_winner ? addr1  : addr0;
          data_d       = pick_winner ? wdata1 : wdata0;
          state_d      = ST_ACC;
        end
      end
      ST_ACC:  state_d = ST_RSP;
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_LDR;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign mem_we   = (state_q == ST_ACC) && we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign ack0     = (state_q == ST_RSP) && (grant_q == REQ_CPU);
  assign ack1     = (state_q == ST_RSP) && (grant_q == REQ_LDR);
  assign busy     = (state_q != ST_IDLE);
  assign rdata    = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed sequences and a
// randomized phase, all checked against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prio_fixed = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, mem_we;
  logic [15:0] rdata, mem_data, mem_out;
  logic [5:0]  mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .prio_fixed(prio_fixed),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Memory with registered read (old data on a same-address write).
  logic [15:0] ram [64];
  initial for (int i = 0; i < 64; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    mem_out <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: a grant happens at an idle edge, the write lands at the
  // following edge, and the ack is visible the cycle after that.
  int          m_left = 0;
  logic        m_grant = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [5:0]  m_addr = '0;
  logic [15:0] m_data = '0, m_rd = '0;
  logic [15:0] exp_mem [64];
  initial for (int i = 0; i < 64; i++) exp_mem[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_last = 1'b1;
    end else if (m_left == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_grant = prio_fixed ? 1'b0 : !m_last;
        else              m_grant = req1;
        m_last = m_grant;
        m_we   = m_grant ? we1 : we0;
        m_addr = m_grant ? addr1 : addr0;
        m_data = m_grant ? wdata1 : wdata0;
        m_left = 2;
      end
    end else begin
      if (m_left == 2) begin
        m_rd = exp_mem[m_addr];
        if (m_we) exp_mem[m_addr] = m_data;
      end
      m_left = m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
      end else begin
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("ack0", 32'(ack0), 32'(m_left == 1 && !m_grant));
        chk("ack1", 32'(ack1), 32'(m_left == 1 && m_grant));
        chk("mem_we", 32'(mem_we), 32'(m_left == 2 && m_we));
        if (m_left == 2) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_left == 2 && m_we) chk("mem_data", 32'(mem_data), 32'(m_data));
        if (m_left == 1 && !m_we) chk("rdata", 32'(rdata), 32'(m_rd));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic req_access(input logic who, input logic we, input logic [5:0] a,
                            input logic [15:0] d, output logic [15:0] rd, output int lat);
    @(posedge clk); #1;
    if (who) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (who ? ack1 : ack0) begin
        lat = i;
        rd  = rdata;
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (who) req1 = 1'b0; else req0 = 1'b0;
  endtask

  typedef struct {
    logic prio;
    logic r0;
    logic r1;
    logic warm0;
    logic e0;
    logic e1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] rd;
    int          lat;
    int          nack;
    int          last_t;
    logic        got_ack;

    vecs[0] = '{prio:1'b0, r0:1'b1, r1:1'b0, warm0:1'b0, e0:1'b1, e1:1'b0};
    vecs[1] = '{prio:1'b0, r0:1'b0, r1:1'b1, warm0:1'b0, e0:1'b0, e1:1'b1};
    vecs[2] = '{prio:1'b0, r0:1'b1, r1:1'b1, warm0:1'b0, e0:1'b1, e1:1'b0};
    vecs[3] = '{prio:1'b1, r0:1'b1, r1:1'b1, warm0:1'b0, e0:1'b1, e1:1'b0};
    vecs[4] = '{prio:1'b0, r0:1'b1, r1:1'b1, warm0:1'b1, e0:1'b0, e1:1'b1};
    vecs[5] = '{prio:1'b1, r0:1'b1, r1:1'b1, warm0:1'b1, e0:1'b1, e1:1'b0};
    vecs[6] = '{prio:1'b0, r0:1'b0, r1:1'b0, warm0:1'b0, e0:1'b0, e1:1'b0};
    vecs[7] = '{prio:1'b1, r0:1'b0, r1:1'b1, warm0:1'b1, e0:1'b0, e1:1'b1};

    // Reset, then idle for 10 cycles
    @(posedge clk); #1;
    chk_en = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({mem_we, ack0, ack1, busy}), 32'd0);
    end

    // Arbitration table, each from a fresh reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      prio_fixed = vecs[v].prio;
      if (vecs[v].warm0) req_access(1'b0, 1'b0, 6'd0, 16'h0, rd, lat);
      @(posedge clk); #1;
      req0 = vecs[v].r0; we0 = 1'b0; addr0 = 6'd0;
      req1 = vecs[v].r1; we1 = 1'b0; addr1 = 6'd0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk($sformatf("vec%0d_ack0", v), 32'(ack0), 32'(vecs[v].e0));
      chk($sformatf("vec%0d_ack1", v), 32'(ack1), 32'(vecs[v].e1));
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); @(posedge clk);
    end

    // Write then read by requester 0
    do_reset();
    prio_fixed = 1'b0;
    req_access(1'b0, 1'b1, 6'd5, 16'h00A5, rd, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    req_access(1'b0, 1'b0, 6'd5, 16'h0, rd, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_back", 32'(rd), 32'h00A5);

    // Round-robin contention: grants 0,1,0,1 every 3 cycles, addrs 1,2
    do_reset();
    prio_fixed = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
    nack = 0;
    last_t = 0;
    for (int i = 1; i <= 20 && nack < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        chk("rr_winner", 32'(ack1), 32'(nack % 2));
        chk("rr_addr", 32'(mem_addr), (nack % 2 == 0) ? 32'd1 : 32'd2);
        if (nack > 0) chk("rr_spacing", 32'(i - last_t), 32'd3);
        last_t = i;
        nack++;
      end
    end
    chk("rr_ack_count", 32'(nack), 32'd4);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    // Fixed priority: only requester 0 served until it drops
    do_reset();
    prio_fixed = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
    nack = 0;
    for (int i = 1; i <= 20 && nack < 3; i++) begin
      @(negedge clk);
      if (ack1) chk("fp_no_ack1", 32'(ack1), 32'd0);
      if (ack0) nack++;
    end
    chk("fp_ack0_count", 32'(nack), 32'd3);
    @(posedge clk); #1;
    req0 = 1'b0;
    got_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (ack1) got_ack = 1'b1;
    end
    chk("fp_ack1_follows", 32'(got_ack), 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;

    // Reset during the ACC cycle of a write aborts it
    do_reset();
    prio_fixed = 1'b0;
    req_access(1'b0, 1'b1, 6'd9, 16'h1234, rd, lat);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd9; wdata0 = 16'hFFFF;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) got_ack = 1'b1;
    end
    chk("abort_no_ack", 32'(got_ack), 32'd0);
    req_access(1'b0, 1'b0, 6'd9, 16'h0, rd, lat);
    chk("abort_mem_kept", 32'(rd), 32'h1234);

    // Address change during ACC does not affect the current access
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd3;
    @(posedge clk); #1;
    addr1 = 6'd4;
    @(negedge clk);
    chk("midchg_addr_cur", 32'(mem_addr), 32'd3);
    @(negedge clk);
    chk("midchg_ack1", 32'(ack1), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("midchg_addr_next", 32'(mem_addr), 32'd4);
    @(negedge clk);
    chk("midchg_ack1_next", 32'(ack1), 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;

    // Randomized traffic, checked cycle by cycle by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic a0, a1;
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      @(posedge clk); #1;
      if ($urandom_range(0, 15) == 0) prio_fixed = ~prio_fixed;
      if (req0) begin
        if (a0) begin
          if ($urandom_range(0, 1) == 0) req0 = 1'b0;
          else begin
            we0 = 1'($urandom); addr0 = 6'($urandom_range(0, 7)); wdata0 = 16'($urandom);
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom); addr0 = 6'($urandom_range(0, 7)); wdata0 = 16'($urandom);
      end
      if (req1) begin
        if (a1) begin
          if ($urandom_range(0, 1) == 0) req1 = 1'b0;
          else begin
            we1 = 1'($urandom); addr1 = 6'($urandom_range(0, 7)); wdata1 = 16'($urandom);
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom); addr1 = 6'($urandom_range(0, 7)); wdata1 = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
